// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths, status flags and helpers for the FPU datapath
package fpu_pkg;

    localparam int FPU_MANT_W = 8;
    localparam int FPU_EXP_W  = 8;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
    } norm_flags_t;

    // Largest biased exponent code (reserved for infinity) for an e-bit field.
    function automatic int unsigned exp_all_ones(input int unsigned e);
        return (32'd1 << e) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_mant_normalize_if.sv
// rtl/fp_mant_normalize_if.sv - adder-result in / normalized-mantissa out handshake bundle
interface fp_mant_normalize_if
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = FPU_MANT_W,
    parameter int EXP_WIDTH  = FPU_EXP_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH+1:0] sum_in;
    logic [EXP_WIDTH-1:0]  exp_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] mant_out;
    logic [EXP_WIDTH-1:0]  exp_out;
    logic                  sign_out;
    logic                  guard_out;
    logic                  zero_out;
    logic                  underflow_out;
    logic                  overflow_out;

    modport master (
        output in_valid, sum_in, exp_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, sign_out, guard_out,
               zero_out, underflow_out, overflow_out
    );

    modport slave (
        input  in_valid, sum_in, exp_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, sign_out, guard_out,
               zero_out, underflow_out, overflow_out
    );

endinterface

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - priority encoder giving the position of the most significant set bit
module fp_lzc #(
    parameter int WIDTH = 10,
    parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [PW-1:0]    pos,
    output logic             all_zero
);

    // Ascending scan: the last set bit seen is the MSB.
    always_comb begin
        pos      = '0;
        all_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                pos      = PW'(i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_mant_normalize.sv
// rtl/fp_mant_normalize.sv - two-stage sign/magnitude extraction and mantissa normalization
module fp_mant_normalize
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = FPU_MANT_W,
    parameter int EXP_WIDTH  = FPU_EXP_W
) (
    input  logic               clk,
    input  logic               rst,
    fp_mant_normalize_if.slave bus
);

    localparam int W  = DATA_WIDTH;
    localparam int E  = EXP_WIDTH;
    localparam int MW = W + 2;
    localparam int PW = $clog2(MW);
    localparam logic [E+1:0] EXP_MAX = (E+2)'(exp_all_ones(E));

    logic          s1_valid;
    logic          s1_sign;
    logic [MW-1:0] s1_mag;
    logic [E-1:0]  s1_exp;

    logic          s2_valid;
    logic [W-1:0]  mant_q;
    logic [E-1:0]  exp_q;
    logic          sign_q;
    logic          guard_q;
    norm_flags_t   flags_q;

    logic          s2_load;
    logic          in_ready_c;
    logic          sum_sign;
    logic [MW-1:0] sum_mag;

    assign s2_load    = !s2_valid || bus.out_ready;
    assign in_ready_c = !s1_valid || s2_load;
    assign sum_sign   = bus.sum_in[MW-1];
    // The most negative sum negates to itself and reads correctly as unsigned 2^(W+1).
    assign sum_mag    = sum_sign ? (~bus.sum_in + MW'(1)) : bus.sum_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_exp   <= '0;
        end else if (in_ready_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign <= sum_sign;
                s1_mag  <= sum_mag;
                s1_exp  <= bus.exp_in;
            end
        end
    end

    logic [PW-1:0] msb_pos;
    logic          mag_zero;

    fp_lzc #(.WIDTH(MW), .PW(PW)) u_lzc (
        .vec      (s1_mag),
        .pos      (msb_pos),
        .all_zero (mag_zero)
    );

    logic [W-1:0]  n_mant;
    logic [E-1:0]  n_exp;
    logic          n_sign;
    logic          n_guard;
    norm_flags_t   n_flags;
    logic [E+1:0]  exp_ext;
    logic [E+1:0]  exp_adj;
    logic [E+1:0]  l_amt;

    // Exponent math runs two bits wide so carries and borrows are visible before truncation.
    always_comb begin
        n_mant  = '0;
        n_exp   = '0;
        n_sign  = s1_sign;
        n_guard = 1'b0;
        n_flags = '0;
        exp_ext = {2'b00, s1_exp};
        exp_adj = '0;
        l_amt   = '0;
        if (mag_zero) begin
            n_sign       = 1'b0;
            n_flags.zero = 1'b1;
        end else if (msb_pos >= PW'(W)) begin
            if (msb_pos == PW'(W + 1)) begin
                n_mant  = s1_mag[MW-1:2];
                n_guard = |s1_mag[1:0];
                exp_adj = exp_ext + (E+2)'(2);
            end else begin
                n_mant  = s1_mag[W:1];
                n_guard = s1_mag[0];
                exp_adj = exp_ext + (E+2)'(1);
            end
            if (exp_adj >= EXP_MAX) begin
                n_flags.overflow = 1'b1;
                n_exp            = '1;
                n_mant           = '0;
                n_guard          = 1'b0;
            end else begin
                n_exp = exp_adj[E-1:0];
            end
        end else begin
            l_amt = (E+2)'(W - 1) - (E+2)'(msb_pos);
            if (l_amt >= exp_ext) begin
                n_flags.underflow = 1'b1;
            end else begin
                n_mant  = s1_mag[W-1:0] << l_amt;
                exp_adj = exp_ext - l_amt;
                n_exp   = exp_adj[E-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            guard_q  <= 1'b0;
            flags_q  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                mant_q  <= n_mant;
                exp_q   <= n_exp;
                sign_q  <= n_sign;
                guard_q <= n_guard;
                flags_q <= n_flags;
            end
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = s2_valid;
    assign bus.mant_out      = mant_q;
    assign bus.exp_out       = exp_q;
    assign bus.sign_out      = sign_q;
    assign bus.guard_out     = guard_q;
    assign bus.zero_out      = flags_q.zero;
    assign bus.underflow_out = flags_q.underflow;
    assign bus.overflow_out  = flags_q.overflow;

endmodule

// File: tb/tb_fp_mant_normalize.sv
// tb/tb_fp_mant_normalize.sv - vector table, random scoreboard and handshake corner cases
module tb_fp_mant_normalize;

    typedef struct packed {
        logic [7:0] mant;
        logic [7:0] e;
        logic       sign;
        logic       guard;
        logic       zero;
        logic       uf;
        logic       of;
    } res_t;

    typedef struct {
        logic [9:0] sum;
        logic [7:0] exp_in;
        res_t       want;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_mant_normalize_if #(.DATA_WIDTH(8), .EXP_WIDTH(8)) bus ();

    fp_mant_normalize #(.DATA_WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   emitted  = 0;
    res_t sb[$];
    logic hold_pending = 1'b0;
    res_t hold_val;

    function automatic res_t mk(input logic [7:0] m, input logic [7:0] e, input logic [4:0] f);
        return {m, e, f};
    endfunction

    // Reference: signed value -> magnitude -> MSB index via $clog2, then scale with integers.
    function automatic res_t model(input logic [9:0] s, input logic [7:0] e);
        res_t r;
        int v, mag, p, sh, ex, l;
        r   = '0;
        v   = s[9] ? int'(s) - 1024 : int'(s);
        mag = (v < 0) ? -v : v;
        if (mag == 0) begin
            r.zero = 1'b1;
            return r;
        end
        r.sign = (v < 0);
        p = $clog2(mag + 1) - 1;
        if (p >= 8) begin
            sh = p - 7;
            ex = int'(e) + sh;
            if (ex >= 255) begin
                r.of = 1'b1;
                r.e  = 8'hFF;
            end else begin
                r.mant  = 8'(mag >> sh);
                r.guard = (mag % (1 << sh)) != 0;
                r.e     = 8'(ex);
            end
        end else begin
            l = 7 - p;
            if (l >= int'(e)) r.uf = 1'b1;
            else begin
                r.mant = 8'(mag * (1 << l));
                r.e    = 8'(int'(e) - l);
            end
        end
        return r;
    endfunction

    function automatic res_t get_out();
        return {bus.mant_out, bus.exp_out, bus.sign_out, bus.guard_out,
                bus.zero_out, bus.underflow_out, bus.overflow_out};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, want);
    endtask

    task automatic step(input logic iv, input logic [9:0] s, input logic [7:0] e,
                        input logic ordy, output logic acc);
        @(posedge clk); #1;
        bus.in_valid  = iv;
        bus.sum_in    = s;
        bus.exp_in    = e;
        bus.out_ready = ordy;
        @(negedge clk);
        if (hold_pending) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(get_out()), 32'(hold_val));
        end
        if (bus.out_valid && bus.out_ready) begin
            emitted++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_beat: got %h required no beat", get_out());
            end else begin
                check("beat", 32'(get_out()), 32'(sb.pop_front()));
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) sb.push_back(model(bus.sum_in, bus.exp_in));
        hold_pending = bus.out_valid && !bus.out_ready;
        hold_val     = get_out();
    endtask

    vec_t       tv[13];
    logic [9:0] bp_sum[4];
    logic       acc;
    int         sent, idx, e0;

    initial begin
        tv[0]  = '{10'h080, 8'd10,  mk(8'h80, 8'd10,  5'b00000), "basic"};
        tv[1]  = '{10'h101, 8'd10,  mk(8'h80, 8'd11,  5'b01000), "carry"};
        tv[2]  = '{10'h3FD, 8'd10,  mk(8'hC0, 8'd4,   5'b10000), "negative"};
        tv[3]  = '{10'h200, 8'd10,  mk(8'h80, 8'd12,  5'b10000), "most_neg"};
        tv[4]  = '{10'h000, 8'd10,  mk(8'h00, 8'd0,   5'b00100), "zero"};
        tv[5]  = '{10'h001, 8'd5,   mk(8'h00, 8'd0,   5'b00010), "underflow"};
        tv[6]  = '{10'h100, 8'hFE,  mk(8'h00, 8'hFF,  5'b00001), "overflow"};
        tv[7]  = '{10'h3FF, 8'd20,  mk(8'h80, 8'd13,  5'b10000), "minus_one"};
        tv[8]  = '{10'h1FF, 8'd3,   mk(8'hFF, 8'd4,   5'b01000), "carry_guard"};
        tv[9]  = '{10'h300, 8'hFD,  mk(8'h80, 8'hFE,  5'b10000), "no_overflow_edge"};
        tv[10] = '{10'h040, 8'd1,   mk(8'h00, 8'd0,   5'b00010), "underflow_edge"};
        tv[11] = '{10'h040, 8'd2,   mk(8'h80, 8'd1,   5'b00000), "no_underflow_edge"};
        tv[12] = '{10'h200, 8'hFD,  mk(8'h00, 8'hFF,  5'b10001), "overflow_shift2"};

        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.exp_in    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_data", 32'(get_out()), 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.sum_in   = tv[i].sum;
            bus.exp_in   = tv[i].exp_in;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check({tv[i].name, "_lat1"}, 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
            check({tv[i].name, "_lat2"}, 32'(bus.out_valid), 32'd1);
            check(tv[i].name, 32'(get_out()), 32'(tv[i].want));
        end
        @(posedge clk);

        sent = 0;
        for (int c = 0; c < 3000 && (sent < 200 || sb.size() != 0); c++) begin
            logic [7:0] e;
            case ($urandom_range(0, 2))
                0:       e = 8'($urandom_range(0, 8));
                1:       e = 8'($urandom_range(247, 255));
                default: e = 8'($urandom);
            endcase
            step((sent < 200) && ($urandom_range(0, 3) != 0), 10'($urandom), e,
                 $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
        end
        check("random_sent", 32'(sent), 32'd200);
        check("random_drained", 32'(sb.size()), 32'd0);

        bp_sum[0] = 10'h080; bp_sum[1] = 10'h101; bp_sum[2] = 10'h3FD; bp_sum[3] = 10'h200;
        idx = 0;
        e0  = emitted;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp_sum[idx], 8'(10 + idx), 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_head", 32'(get_out()), 32'(mk(8'h80, 8'd10, 5'b00000)));
        for (int c = 0; c < 20 && (idx < 4 || sb.size() != 0); c++) begin
            step(idx < 4, bp_sum[idx % 4], 8'(10 + idx), 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_emitted", 32'(emitted - e0), 32'd4);
        check("bp_drained", 32'(sb.size()), 32'd0);

        step(1'b1, 10'h101, 8'd30, 1'b0, acc);
        step(1'b1, 10'h3FD, 8'd31, 1'b0, acc);
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_data", 32'(get_out()), 32'd0);
        sb.delete();
        hold_pending = 1'b0;
        e0 = emitted;
        repeat (10) step(1'b0, 10'h0, 8'h0, 1'b1, acc);
        check("rst_no_emit", 32'(emitted - e0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
